out_port_mc: RTL and testbench

//  Multi-channel buffered output port, parametrised successor of the single-register OUT port.

---
 rtl/out_port_pkg.sv | 15 +
 rtl/out_port_chfifo.sv | 72 +++++++
 rtl/out_port_mc.sv | 193 +++++++++++++++++++
 tb/tb_out_port_mc.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_port_pkg.sv
// Shared types and helpers for the multi-channel buffered output port.
// Holds the arbiter FSM state type and the channel-index width helper.
package out_port_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Width of a channel index; a single-channel port still needs one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/out_port_chfifo.sv
// One per-channel FIFO of the output port.
// Pushes into a full FIFO and pops from an empty one are ignored here as a
// second line of defence. The top already qualifies both against the
// registered count. The head word is always visible on rdData_o.
module out_port_chfifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wrData_i,
    output logic [WIDTH-1:0]       rdData_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULLCNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW:0]      count_q, count_d;
    logic             doPush, doPop;

    assign doPush = push_i && (count_q != FULLCNT);
    assign doPop  = pop_i && (count_q != '0);

    // Next pointers wrap naturally because DEPTH is a power of two.
    // A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array. It has no reset because the count alone decides validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wrData_i;
        end
    end

    assign rdData_o = mem_q[rdPtr_q];
    assign count_o  = count_q;

endmodule

// File: rtl/out_port_mc.sv
// Multi-channel buffered output port.
// The pipeline writes words into per-channel FIFOs. A round-robin arbiter
// drains them over one shared valid/ready bus. Per-channel "last written"
// registers keep the old level-style view of each channel.
// Optional feature: define OUT_PORT_DROP_CNT_EN to add an 8-bit saturating
// counter of dropped writes on port drop_cnt.
module out_port_mc
    import out_port_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ch_w(NUM_CH)-1:0]   wr_ch,
    input  logic [WIDTH-1:0]          wr_data,
    output logic [NUM_CH-1:0]         full,
    output logic [NUM_CH-1:0]         empty,
    output logic [NUM_CH-1:0]         overflow,
    output logic [NUM_CH*WIDTH-1:0]   last_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ch_w(NUM_CH)-1:0]   out_ch,
    output logic [WIDTH-1:0]          out_data
`ifdef OUT_PORT_DROP_CNT_EN
    ,
    output logic [7:0]                drop_cnt
`endif
);

    localparam int CW   = ch_w(NUM_CH);
    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam logic [CNTW-1:0] FULLCNT = CNTW'(DEPTH);

    logic [WIDTH-1:0]        rdData [NUM_CH];
    logic [CNTW-1:0]         count  [NUM_CH];
    logic [NUM_CH-1:0]       push, pop, drop;
    logic [NUM_CH-1:0]       fullVec, emptyVec;
    logic                    wrInRange;

    state_e                  state_q;
    logic                    outValid_q;
    logic [CW-1:0]           outCh_q;
    logic [WIDTH-1:0]        outData_q;
    logic [CW-1:0]           rr_q;
    logic [NUM_CH*WIDTH-1:0] lastData_q;
    logic [NUM_CH-1:0]       overflow_q;

    logic [CW-1:0]           rrAfter, rrBase, pickCh;
    logic [WIDTH-1:0]        pickData;
    logic                    anyPending, popEn;
    int                      scanIdx;

    // Writes to channel numbers that do not exist vanish without any side effect.
    assign wrInRange = wr_en && (int'(wr_ch) < NUM_CH);

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            localparam logic [CW-1:0] KIDX = CW'(k);

            assign fullVec[k]  = (count[k] == FULLCNT);
            assign emptyVec[k] = (count[k] == '0);
            assign push[k]     = wrInRange && (wr_ch == KIDX) && !fullVec[k];
            assign drop[k]     = wrInRange && (wr_ch == KIDX) && fullVec[k];
            assign pop[k]      = popEn && (pickCh == KIDX);

            out_port_chfifo #(
                .WIDTH(WIDTH),
                .DEPTH(DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .push_i  (push[k]),
                .pop_i   (pop[k]),
                .wrData_i(wr_data),
                .rdData_o(rdData[k]),
                .count_o (count[k])
            );
        end
    endgenerate

    assign full  = fullVec;
    assign empty = emptyVec;

    // Track the last accepted word per channel and latch sticky overflow flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastData_q <= '0;
            overflow_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (push[k]) begin
                    lastData_q[k*WIDTH +: WIDTH] <= wr_data;
                end
                if (drop[k]) begin
                    overflow_q[k] <= 1'b1;
                end
            end
        end
    end

    assign last_data = lastData_q;
    assign overflow  = overflow_q;

    // Round-robin pointer after the presented word completes.
    // The pointer moves to the channel after it and wraps at NUM_CH.
    assign rrAfter    = (int'(outCh_q) == NUM_CH - 1) ? '0 : outCh_q + CW'(1);
    assign anyPending = ~&emptyVec;
    assign popEn      = anyPending && ((state_q == IDLE) || out_ready);
    assign pickData   = rdData[pickCh];

    // Pick the first non-empty channel at or after the round-robin base.
    // When a transfer completes this cycle, the base is already the advanced pointer.
    // The scan runs downward so that the closest channel is assigned last and wins.
    always_comb begin
        rrBase  = rr_q;
        pickCh  = '0;
        scanIdx = 0;
        if ((state_q == HOLD) && out_ready) begin
            rrBase = rrAfter;
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            scanIdx = int'(rrBase) + i;
            if (scanIdx >= NUM_CH) begin
                scanIdx = scanIdx - NUM_CH;
            end
            if (!emptyVec[CW'(scanIdx)]) begin
                pickCh = CW'(scanIdx);
            end
        end
    end

    // Output FSM: load a word from IDLE and hold it until accepted.
    // On acceptance it reloads back-to-back, or it drops valid when every channel is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            outCh_q    <= '0;
            outData_q  <= '0;
            rr_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyPending) begin
                        state_q    <= HOLD;
                        outValid_q <= 1'b1;
                        outCh_q    <= pickCh;
                        outData_q  <= pickData;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        rr_q <= rrAfter;
                        if (anyPending) begin
                            outCh_q   <= pickCh;
                            outData_q <= pickData;
                        end else begin
                            state_q    <= IDLE;
                            outValid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = outValid_q;
    assign out_ch    = outCh_q;
    assign out_data  = outData_q;

`ifdef OUT_PORT_DROP_CNT_EN
    logic [7:0] dropCnt_q;

    // Count dropped writes and saturate at 255. At most one write arrives per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dropCnt_q <= '0;
        end else if ((|drop) && (dropCnt_q != 8'hFF)) begin
            dropCnt_q <= dropCnt_q + 8'd1;
        end
    end

    assign drop_cnt = dropCnt_q;
`endif

endmodule

// File: tb/tb_out_port_mc.sv
// Directed testbench for out_port_mc.
// The main instance uses 4 channels. A second 5-channel instance exercises
// channel indices that do not exist.
module tb_out_port_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

   // main instance, NUM_CH=4
    logic        wrEn = 1'b0;
    logic [1:0]  wrCh = '0;
    logic [15:0] wrData = '0;
    logic [3:0]  full, empty, overflow;
    logic [63:0] lastData;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [1:0]  outCh;
    logic [15:0] outData;

   // second instance, NUM_CH=5
    logic        wrEn5 = 1'b0;
    logic [2:0]  wrCh5 = '0;
    logic [15:0] wrData5 = '0;
    logic [4:0]  full5, empty5, overflow5;
    logic [79:0] lastData5;
    logic        outValid5;
    logic        outReady5 = 1'b0;
    logic [2:0]  outCh5;
    logic [15:0] outData5;

`ifdef OUT_PORT_DROP_CNT_EN
    logic [7:0]  dropCnt, dropCnt5;
`endif

    int nChecks = 0;
    int nBad    = 0;

    always #5 clk = ~clk;

    out_port_mc #(.WIDTH(16), .NUM_CH(4), .DEPTH(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wrEn),
        .wr_ch    (wrCh),
        .wr_data  (wrData),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .last_data(lastData),
        .out_valid(outValid),
        .out_ready(outReady),
        .out_ch   (outCh),
        .out_data (outData)
`ifdef OUT_PORT_DROP_CNT_EN
        ,
        .drop_cnt (dropCnt)
`endif
    );

    out_port_mc #(.WIDTH(16), .NUM_CH(5), .DEPTH(4)) u_dut5 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wrEn5),
        .wr_ch    (wrCh5),
        .wr_data  (wrData5),
        .full     (full5),
        .empty    (empty5),
        .overflow (overflow5),
        .last_data(lastData5),
        .out_valid(outValid5),
        .out_ready(outReady5),
        .out_ch   (outCh5),
        .out_data (outData5)
`ifdef OUT_PORT_DROP_CNT_EN
        ,
        .drop_cnt (dropCnt5)
`endif
    );

    // Count one comparison and report it when the observed value differs from the expected one.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle write to the main instance.
    task automatic applyStimulus(input logic [1:0] ch, input logic [15:0] data);
        wrEn   = 1'b1;
        wrCh   = ch;
        wrData = data;
        tick();
        wrEn   = 1'b0;
    endtask

    logic [15:0] drainData [4];

    initial begin
       // reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", outValid, 0);
        checkOutput("rst_empty", empty, 4'hF);
        checkOutput("rst_full", full, 4'h0);
        checkOutput("rst_ovf", overflow, 4'h0);
        checkOutput("rst_last", lastData, 64'h0);
        checkOutput("rst_ch", outCh, 0);
        checkOutput("rst_data", outData, 0);
`ifdef OUT_PORT_DROP_CNT_EN
        checkOutput("rst_dcnt", dropCnt, 0);
`endif
        rst = 1'b1;
        tick();

       // round-robin order: ch0, then ch1, then ch2, on consecutive cycles
        outReady = 1'b0;
        applyStimulus(2'd0, 16'h000A);
        applyStimulus(2'd2, 16'h000B);
        applyStimulus(2'd1, 16'h000C);
        checkOutput("rr0_valid", outValid, 1);
        checkOutput("rr0_ch", outCh, 0);
        checkOutput("rr0_data", outData, 16'h000A);
        outReady = 1'b1;
        tick();
        checkOutput("rr1_valid", outValid, 1);
        checkOutput("rr1_ch", outCh, 1);
        checkOutput("rr1_data", outData, 16'h000C);
        tick();
        checkOutput("rr2_valid", outValid, 1);
        checkOutput("rr2_ch", outCh, 2);
        checkOutput("rr2_data", outData, 16'h000B);
        tick();
        checkOutput("rr_idle", outValid, 0);
        checkOutput("rr_last", lastData, 64'h0000_000B_000C_000A);
        checkOutput("rr_empty", empty, 4'hF);

       // overflow on ch3 while ch0's word is held on the bus
        outReady = 1'b0;
        applyStimulus(2'd0, 16'h1111);
        applyStimulus(2'd3, 16'h3001);
        applyStimulus(2'd3, 16'h3002);
        applyStimulus(2'd3, 16'h3003);
        applyStimulus(2'd3, 16'h3004);
        checkOutput("ovf_full_pre", full, 4'b1000);
        checkOutput("ovf_flag_pre", overflow, 4'b0000);
        applyStimulus(2'd3, 16'hDEAD);
        checkOutput("ovf_full", full, 4'b1000);
        checkOutput("ovf_flag", overflow, 4'b1000);
        checkOutput("ovf_last3", lastData[63:48], 16'h3004);
`ifdef OUT_PORT_DROP_CNT_EN
        checkOutput("ovf_dcnt", dropCnt, 1);
`endif

       // backpressure: the held word stays stable, then ch3 drains in order
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_valid", outValid, 1);
            checkOutput("bp_ch", outCh, 0);
            checkOutput("bp_data", outData, 16'h1111);
        end
        checkOutput("bp_empty", empty, 4'b0111);
        outReady = 1'b1;
        drainData = '{16'h3001, 16'h3002, 16'h3003, 16'h3004};
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("bp_drain_valid", outValid, 1);
            checkOutput("bp_drain_ch", outCh, 3);
            checkOutput("bp_drain_data", outData, drainData[i]);
        end
        tick();
        checkOutput("bp_idle", outValid, 0);

       // push and pop on ch1 in the same cycle at count 2
        outReady = 1'b0;
        applyStimulus(2'd0, 16'h5000);
        applyStimulus(2'd1, 16'h5101);
        applyStimulus(2'd1, 16'h5102);
        checkOutput("pp_hold_ch", outCh, 0);
        checkOutput("pp_hold_data", outData, 16'h5000);
        outReady = 1'b1;
        applyStimulus(2'd1, 16'h5103);
        outReady = 1'b0;
        checkOutput("pp_ch", outCh, 1);
        checkOutput("pp_data", outData, 16'h5101);
        checkOutput("pp_empty", empty, 4'b1101);
        checkOutput("pp_full2", full, 4'b0000);
        applyStimulus(2'd1, 16'h5104);
        checkOutput("pp_full3", full, 4'b0000);
        applyStimulus(2'd1, 16'h5105);
        checkOutput("pp_full4", full, 4'b0010);

       // a push to full ch1 is dropped even though ch1 pops in the same cycle
        outReady = 1'b1;
        applyStimulus(2'd1, 16'h51FF);
        checkOutput("ppf_ovf", overflow, 4'b1010);
        checkOutput("ppf_ch", outCh, 1);
        checkOutput("ppf_data", outData, 16'h5102);
        checkOutput("ppf_full", full, 4'b0000);
        checkOutput("ppf_last1", lastData[31:16], 16'h5105);
`ifdef OUT_PORT_DROP_CNT_EN
        checkOutput("ppf_dcnt", dropCnt, 2);
`endif
        drainData = '{16'h5103, 16'h5104, 16'h5105, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("ppf_drain_valid", outValid, 1);
            checkOutput("ppf_drain_ch", outCh, 1);
            checkOutput("ppf_drain_data", outData, drainData[i]);
        end
        tick();
        checkOutput("ppf_idle", outValid, 0);

       // asynchronous reset while a word is held on the bus
        outReady = 1'b0;
        applyStimulus(2'd2, 16'h1234);
        applyStimulus(2'd0, 16'h0777);
        checkOutput("ar_pre_valid", outValid, 1);
        checkOutput("ar_pre_data", outData, 16'h1234);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("ar_valid", outValid, 0);
        checkOutput("ar_empty", empty, 4'hF);
        checkOutput("ar_ovf", overflow, 4'h0);
        checkOutput("ar_last", lastData, 64'h0);
        checkOutput("ar_data", outData, 0);
        #2;
        rst = 1'b1;
        tick();
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("ar_post_valid", outValid, 0);
        end

`ifdef OUT_PORT_DROP_CNT_EN
       // drop counter saturation on ch0
        outReady = 1'b0;
        checkOutput("sat_dcnt0", dropCnt, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'd0, 16'h0100 + 16'(i));
        end
        checkOutput("sat_full", full, 4'b0001);
        wrEn   = 1'b1;
        wrCh   = 2'd0;
        wrData = 16'hBEEF;
        repeat (300) tick();
        wrEn   = 1'b0;
        checkOutput("sat_dcnt", dropCnt, 255);
        checkOutput("sat_ovf", overflow, 4'b0001);
        checkOutput("sat_last0", lastData[15:0], 16'h0104);
`endif

       // out-of-range channel indices on the 5-channel instance
        for (int c = 5; c < 8; c++) begin
            wrEn5   = 1'b1;
            wrCh5   = 3'(c);
            wrData5 = 16'hF00D;
            tick();
        end
        wrEn5 = 1'b0;
        tick();
        checkOutput("oor_empty", empty5, 5'h1F);
        checkOutput("oor_full", full5, 5'h00);
        checkOutput("oor_ovf", overflow5, 5'h00);
        checkOutput("oor_valid", outValid5, 0);
        checkOutput("oor_last", {63'h0, (lastData5 == 80'h0)}, 1);
`ifdef OUT_PORT_DROP_CNT_EN
        checkOutput("oor_dcnt", dropCnt5, 0);
`endif
        wrEn5   = 1'b1;
        wrCh5   = 3'd4;
        wrData5 = 16'h4444;
        tick();
        wrEn5 = 1'b0;
        tick();
        checkOutput("ch4_valid", outValid5, 1);
        checkOutput("ch4_ch", outCh5, 4);
        checkOutput("ch4_data", outData5, 16'h4444);
        checkOutput("ch4_last", lastData5[79:64], 16'h4444);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
